// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back arbiter.
// Entry layout matches the default AW=5 / DW=32 configuration.
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WB_ALU,
      WB_LD
   } wb_state_t;

   localparam int WB_DEPTH = 2;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small generic FIFO: zero-latency head, push lands next edge, flush empties it.
// Backpressure is the caller's job: never push when full or pop when empty.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W = 37,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          core_clk,
   input  logic          arst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [CW-1:0] count,
   output logic          head_vld,
   output logic [W-1:0]  head_dat
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge core_clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

   assign head_vld = (count != '0);
   assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: load > buffered ALU > ALU bypass, registered outputs, 1-cycle latency.
// ALU is stalled (aluReady=0) only while the 2-entry pending FIFO is full; loads never stall.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          flush,
   input  logic          aluValid,
   input  logic [AW-1:0] aluRd,
   input  logic [DW-1:0] aluResult,
   output logic          aluReady,
   input  logic          ldValid,
   input  logic [AW-1:0] ldRd,
   input  logic [DW-1:0] ldData,
   output logic          ALUM2Reg,
   output logic [DW-1:0] result,
   output logic [DW-1:0] DataOut,
   output logic [AW-1:0] writeReg,
   output logic          RegWre,
   output logic [1:0]    pending
);

   wb_state_t     state, state_nxt;
   wb_entry_t     alu_ent, head_ent;
   logic          alu_acc, head_vld, fifo_push, fifo_pop;
   logic          alum2reg_nxt, regwre_nxt;
   logic [DW-1:0] result_nxt, dataout_nxt;
   logic [AW-1:0] writereg_nxt;

   assign aluReady = (pending != 2'(DEPTH));
   assign alu_acc  = aluValid && aluReady && !flush;
   assign alu_ent  = '{rd: aluRd, data: aluResult};

   wb_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(wb_entry_t))
   ) u_fifo (
      .core_clk (CLK),
      .arst_n   (RST),
      .flush    (flush),
      .push     (fifo_push),
      .push_dat (alu_ent),
      .pop      (fifo_pop),
      .count    (pending),
      .head_vld (head_vld),
      .head_dat (head_ent)
   );

   always_comb begin
      state_nxt    = IDLE;
      fifo_push    = alu_acc;
      fifo_pop     = 1'b0;
      // After an idle cycle the selector keeps pointing where it last did.
      alum2reg_nxt = (state == IDLE) ? ALUM2Reg : (state == WB_LD);
      result_nxt   = result;
      dataout_nxt  = DataOut;
      writereg_nxt = writeReg;

      if (ldValid) begin
         state_nxt    = WB_LD;
         alum2reg_nxt = 1'b1;
         dataout_nxt  = ldData;
         writereg_nxt = ldRd;
      end else if (head_vld && !flush) begin
         state_nxt    = WB_ALU;
         fifo_pop     = 1'b1;
         alum2reg_nxt = 1'b0;
         result_nxt   = head_ent.data;
         writereg_nxt = head_ent.rd;
      end else if (alu_acc) begin
         // FIFO is empty here: the request goes straight out without being stored.
         state_nxt    = WB_ALU;
         fifo_push    = 1'b0;
         alum2reg_nxt = 1'b0;
         result_nxt   = alu_ent.data;
         writereg_nxt = alu_ent.rd;
      end

      regwre_nxt = (state_nxt != IDLE) && (writereg_nxt != REG_ZERO);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         ALUM2Reg <= 1'b0;
         result   <= '0;
         DataOut  <= '0;
         writeReg <= '0;
         RegWre   <= 1'b0;
      end else begin
         state    <= state_nxt;
         ALUM2Reg <= alum2reg_nxt;
         result   <= result_nxt;
         DataOut  <= dataout_nxt;
         writeReg <= writereg_nxt;
         RegWre   <= regwre_nxt;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_wb_port_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          flush = 1'b0;
   logic          aluValid = 1'b0;
   logic [AW-1:0] aluRd = '0;
   logic [DW-1:0] aluResult = '0;
   logic          ldValid = 1'b0;
   logic [AW-1:0] ldRd = '0;
   logic [DW-1:0] ldData = '0;
   logic          aluReady, ALUM2Reg, RegWre;
   logic [DW-1:0] result, DataOut;
   logic [AW-1:0] writeReg;
   logic [1:0]    pending;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   logic          m_sel;
   logic [DW-1:0] m_result, m_dataout;
   logic [AW-1:0] m_wr;
   logic          m_wre;

   wb_port_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (flush),
      .aluValid  (aluValid),
      .aluRd     (aluRd),
      .aluResult (aluResult),
      .aluReady  (aluReady),
      .ldValid   (ldValid),
      .ldRd      (ldRd),
      .ldData    (ldData),
      .ALUM2Reg  (ALUM2Reg),
      .result    (result),
      .DataOut   (DataOut),
      .writeReg  (writeReg),
      .RegWre    (RegWre),
      .pending   (pending)
   );

   always #5 CLK = ~CLK;

   task automatic model_reset();
      mq.delete();
      m_sel = 0; m_result = '0; m_dataout = '0; m_wr = '0; m_wre = 0;
   endtask

   // Pending writes form an ordered list; a load jumps ahead, flush empties it.
   task automatic step();
      bit   acc;
      ent_t e;
      acc = aluValid && (mq.size() < 2) && !flush;
      if (flush) mq.delete();
      if (acc) mq.push_back('{aluRd, aluResult});
      m_wre = 0;
      if (ldValid) begin
         m_sel = 1; m_dataout = ldData; m_wr = ldRd; m_wre = (ldRd != 0);
      end else if (!flush && mq.size() > 0) begin
         e = mq.pop_front();
         m_sel = 0; m_result = e.data; m_wr = e.rd; m_wre = (e.rd != 0);
      end
      @(posedge CLK); #1;
   endtask

   task automatic idle_inputs();
      aluValid = 0; ldValid = 0; flush = 0;
   endtask

   task automatic test_reset();
      model_reset();
      RST = 0; aluValid = 1; aluRd = 5'd3; aluResult = 32'h11;
      repeat (2) @(posedge CLK);
      #1;
      n_total++; if (RegWre !== 1'b0) $display("FAIL rst_regwre got %0b want 0", RegWre); else n_pass++;
      n_total++; if (ALUM2Reg !== 1'b0) $display("FAIL rst_alum2reg got %0b want 0", ALUM2Reg); else n_pass++;
      n_total++; if (result !== 32'h0) $display("FAIL rst_result got %h want 0", result); else n_pass++;
      n_total++; if (DataOut !== 32'h0) $display("FAIL rst_dataout got %h want 0", DataOut); else n_pass++;
      n_total++; if (writeReg !== 5'd0) $display("FAIL rst_writereg got %0d want 0", writeReg); else n_pass++;
      n_total++; if (pending !== 2'd0) $display("FAIL rst_pending got %0d want 0", pending); else n_pass++;
      n_total++; if (aluReady !== 1'b1) $display("FAIL rst_aluready got %0b want 1", aluReady); else n_pass++;
      RST = 1;
      step();
      idle_inputs();
      n_total++; if (RegWre !== 1'b1) $display("FAIL first_regwre got %0b want 1", RegWre); else n_pass++;
      n_total++; if (ALUM2Reg !== 1'b0) $display("FAIL first_alum2reg got %0b want 0", ALUM2Reg); else n_pass++;
      n_total++; if (writeReg !== 5'd3) $display("FAIL first_writereg got %0d want 3", writeReg); else n_pass++;
      n_total++; if (result !== 32'h11) $display("FAIL first_result got %h want 11", result); else n_pass++;
      step();
      n_total++; if (RegWre !== 1'b0) $display("FAIL first_idle_regwre got %0b want 0", RegWre); else n_pass++;
   endtask

   task automatic test_collision();
      aluValid = 1; aluRd = 5'd4; aluResult = 32'hA;
      ldValid = 1; ldRd = 5'd5; ldData = 32'hB;
      step();
      idle_inputs();
      n_total++; if (ALUM2Reg !== 1'b1) $display("FAIL coll_ld_sel got %0b want 1", ALUM2Reg); else n_pass++;
      n_total++; if (DataOut !== 32'hB) $display("FAIL coll_ld_data got %h want b", DataOut); else n_pass++;
      n_total++; if (writeReg !== 5'd5) $display("FAIL coll_ld_rd got %0d want 5", writeReg); else n_pass++;
      n_total++; if (RegWre !== 1'b1) $display("FAIL coll_ld_wre got %0b want 1", RegWre); else n_pass++;
      n_total++; if (pending !== 2'd1) $display("FAIL coll_pending1 got %0d want 1", pending); else n_pass++;
      step();
      n_total++; if (ALUM2Reg !== 1'b0) $display("FAIL coll_alu_sel got %0b want 0", ALUM2Reg); else n_pass++;
      n_total++; if (writeReg !== 5'd4) $display("FAIL coll_alu_rd got %0d want 4", writeReg); else n_pass++;
      n_total++; if (result !== 32'hA) $display("FAIL coll_alu_data got %h want a", result); else n_pass++;
      n_total++; if (pending !== 2'd0) $display("FAIL coll_pending0 got %0d want 0", pending); else n_pass++;
   endtask

   task automatic test_full_fifo();
      int idx = 0;
      int nld = 0;
      int order[$];
      bit acc;
      for (int k = 0; k < 9; k++) begin
         ldValid = (k < 3); ldRd = 5'(10 + k); ldData = 32'(32'h200 + k);
         aluValid = (idx < 3); aluRd = 5'(idx + 1); aluResult = 32'(32'h100 + idx);
         if (k == 2 || k == 3) begin
            n_total++; if (aluReady !== 1'b0) $display("FAIL full_ready_k%0d got %0b want 0", k, aluReady); else n_pass++;
         end
         acc = aluValid && aluReady;
         step();
         if (acc) idx++;
         if (k == 1) begin
            n_total++; if (pending !== 2'd2) $display("FAIL full_pending got %0d want 2", pending); else n_pass++;
         end
         if (RegWre && ALUM2Reg) nld++;
         if (RegWre && !ALUM2Reg) order.push_back(int'(writeReg));
      end
      idle_inputs();
      n_total++; if (nld !== 3) $display("FAIL full_loads got %0d want 3", nld); else n_pass++;
      n_total++; if (order.size() !== 3) $display("FAIL full_alu_count got %0d want 3", order.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (order.size() <= i || order[i] !== i + 1) $display("FAIL full_order_%0d got %0d want %0d", i, (order.size() > i) ? order[i] : -1, i + 1);
         else n_pass++;
      end
   endtask

   task automatic test_zero_reg();
      ldValid = 1; ldRd = 5'd0; ldData = 32'h55;
      step();
      idle_inputs();
      n_total++; if (RegWre !== 1'b0) $display("FAIL zero_ld_wre got %0b want 0", RegWre); else n_pass++;
      n_total++; if (ALUM2Reg !== 1'b1) $display("FAIL zero_ld_sel got %0b want 1", ALUM2Reg); else n_pass++;
      n_total++; if (pending !== 2'd0) $display("FAIL zero_ld_pending got %0d want 0", pending); else n_pass++;
      aluValid = 1; aluRd = 5'd0; aluResult = 32'h66;
      step();
      idle_inputs();
      n_total++; if (RegWre !== 1'b0) $display("FAIL zero_alu_wre got %0b want 0", RegWre); else n_pass++;
      n_total++; if (pending !== 2'd0) $display("FAIL zero_alu_pending got %0d want 0", pending); else n_pass++;
      step();
      n_total++; if (RegWre !== 1'b0) $display("FAIL zero_after_wre got %0b want 0", RegWre); else n_pass++;
   endtask

   task automatic fill_two();
      for (int k = 0; k < 2; k++) begin
         ldValid = 1; ldRd = 5'(20 + k); ldData = 32'(32'h300 + k);
         aluValid = 1; aluRd = 5'(8 + k); aluResult = 32'(32'h400 + k);
         step();
      end
      idle_inputs();
   endtask

   task automatic test_flush();
      int nalu = 0;
      fill_two();
      n_total++; if (pending !== 2'd2) $display("FAIL flush_prefill got %0d want 2", pending); else n_pass++;
      flush = 1; ldValid = 1; ldRd = 5'd7; ldData = 32'h77;
      aluValid = 1; aluRd = 5'd13; aluResult = 32'h99;
      step();
      idle_inputs();
      n_total++; if (RegWre !== 1'b1) $display("FAIL flush_ld_wre got %0b want 1", RegWre); else n_pass++;
      n_total++; if (writeReg !== 5'd7) $display("FAIL flush_ld_rd got %0d want 7", writeReg); else n_pass++;
      n_total++; if (DataOut !== 32'h77) $display("FAIL flush_ld_data got %h want 77", DataOut); else n_pass++;
      n_total++; if (pending !== 2'd0) $display("FAIL flush_pending got %0d want 0", pending); else n_pass++;
      repeat (4) begin
         step();
         if (RegWre) nalu++;
      end
      n_total++; if (nalu !== 0) $display("FAIL flush_stale_writes got %0d want 0", nalu); else n_pass++;
   endtask

   task automatic pulse_reset();
      RST = 0;
      #1;
      n_total++; if (RegWre !== 1'b0) $display("FAIL mrst_wre got %0b want 0", RegWre); else n_pass++;
      n_total++; if (writeReg !== 5'd0) $display("FAIL mrst_rd got %0d want 0", writeReg); else n_pass++;
      n_total++; if (DataOut !== 32'h0) $display("FAIL mrst_dataout got %h want 0", DataOut); else n_pass++;
      n_total++; if (result !== 32'h0) $display("FAIL mrst_result got %h want 0", result); else n_pass++;
      n_total++; if (pending !== 2'd0) $display("FAIL mrst_pending got %0d want 0", pending); else n_pass++;
      #3;
      RST = 1;
      model_reset();
   endtask

   task automatic test_mid_reset();
      int nwr = 0;
      fill_two();
      pulse_reset();
      repeat (3) begin
         step();
         if (RegWre || pending != 0) nwr++;
      end
      n_total++; if (nwr !== 0) $display("FAIL mrst_stale got %0d want 0", nwr); else n_pass++;
   endtask

   task automatic test_random();
      bit exp_rdy;
      fill_two();
      pulse_reset();
      for (int c = 0; c < 400; c++) begin
         if (!(aluValid && !aluReady)) begin
            aluValid = ($urandom_range(0, 2) != 0);
            aluRd = 5'($urandom_range(0, 31));
            aluResult = $urandom;
         end
         ldValid = ($urandom_range(0, 2) == 0);
         ldRd = 5'($urandom_range(0, 31));
         ldData = $urandom;
         flush = ($urandom_range(0, 19) == 0);
         exp_rdy = (mq.size() != 2);
         n_total++; if (aluReady !== exp_rdy) $display("FAIL rnd_ready c%0d got %0b want %0b", c, aluReady, exp_rdy); else n_pass++;
         step();
         n_total++; if (RegWre !== m_wre) $display("FAIL rnd_wre c%0d got %0b want %0b", c, RegWre, m_wre); else n_pass++;
         n_total++; if (ALUM2Reg !== m_sel) $display("FAIL rnd_sel c%0d got %0b want %0b", c, ALUM2Reg, m_sel); else n_pass++;
         n_total++; if (writeReg !== m_wr) $display("FAIL rnd_rd c%0d got %0d want %0d", c, writeReg, m_wr); else n_pass++;
         n_total++; if (result !== m_result) $display("FAIL rnd_result c%0d got %h want %h", c, result, m_result); else n_pass++;
         n_total++; if (DataOut !== m_dataout) $display("FAIL rnd_dataout c%0d got %h want %h", c, DataOut, m_dataout); else n_pass++;
         n_total++; if (pending !== 2'(mq.size())) $display("FAIL rnd_pending c%0d got %0d want %0d", c, pending, mq.size()); else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_collision();
      test_full_fifo();
      test_zero_reg();
      test_flush();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
